// File: rtl/axil_arbiter_2m.sv
// Two-master to one-slave AXI4-Lite arbiter with one outstanding transaction.
// The grant is registered in IDLE and held until the B or R handshake closes the transfer.
module axil_arbiter_2m #(
  parameter int FIXED_PRIO  = 0,
  parameter int WRITE_FIRST = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] m0_AWdata,
  input  logic [2:0]  m0_AWprot,
  input  logic        m0_AWvalid,
  output logic        m0_AWready,
  input  logic [31:0] m0_Wdata,
  input  logic [3:0]  m0_Wstrb,
  input  logic        m0_Wvalid,
  output logic        m0_Wready,
  output logic        m0_Bvalid,
  input  logic        m0_Bready,
  input  logic [31:0] m0_ARdata,
  input  logic [2:0]  m0_ARprot,
  input  logic        m0_ARvalid,
  output logic        m0_ARready,
  output logic [31:0] m0_Rdata,
  output logic        m0_Rvalid,
  input  logic        m0_Rready,
  input  logic [31:0] m1_AWdata,
  input  logic [2:0]  m1_AWprot,
  input  logic        m1_AWvalid,
  output logic        m1_AWready,
  input  logic [31:0] m1_Wdata,
  input  logic [3:0]  m1_Wstrb,
  input  logic        m1_Wvalid,
  output logic        m1_Wready,
  output logic        m1_Bvalid,
  input  logic        m1_Bready,
  input  logic [31:0] m1_ARdata,
  input  logic [2:0]  m1_ARprot,
  input  logic        m1_ARvalid,
  output logic        m1_ARready,
  output logic [31:0] m1_Rdata,
  output logic        m1_Rvalid,
  input  logic        m1_Rready,
  output logic [31:0] s_AWdata,
  output logic [2:0]  s_AWprot,
  output logic        s_AWvalid,
  input  logic        s_AWready,
  output logic [31:0] s_Wdata,
  output logic [3:0]  s_Wstrb,
  output logic        s_Wvalid,
  input  logic        s_Wready,
  input  logic        s_Bvalid,
  output logic        s_Bready,
  output logic [31:0] s_ARdata,
  output logic [2:0]  s_ARprot,
  output logic        s_ARvalid,
  input  logic        s_ARready,
  input  logic [31:0] s_Rdata,
  input  logic        s_Rvalid,
  output logic        s_Rready,
  output logic [1:0]  owner
);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t state_q, state_d;
  logic   gnt_q, gnt_d;
  logic   last_q, last_d;
  logic   aw_done_q, aw_done_d;
  logic   w_done_q, w_done_d;
  logic   ar_done_q, ar_done_d;

  logic req0_wr, req0_rd, req1_wr, req1_rd, req0, req1;
  logic win, win_wr, win_rd;

  assign req0_wr = m0_AWvalid | m0_Wvalid;
  assign req0_rd = m0_ARvalid;
  assign req1_wr = m1_AWvalid | m1_Wvalid;
  assign req1_rd = m1_ARvalid;
  assign req0    = req0_wr | req0_rd;
  assign req1    = req1_wr | req1_rd;

  // Master-side signals of whichever master currently holds the grant
  logic [31:0] g_awdata, g_wdata, g_ardata;
  logic [2:0]  g_awprot, g_arprot;
  logic [3:0]  g_wstrb;
  logic        g_awvalid, g_wvalid, g_arvalid, g_bready, g_rready;

  assign g_awdata  = gnt_q ? m1_AWdata  : m0_AWdata;
  assign g_awprot  = gnt_q ? m1_AWprot  : m0_AWprot;
  assign g_awvalid = gnt_q ? m1_AWvalid : m0_AWvalid;
  assign g_wdata   = gnt_q ? m1_Wdata   : m0_Wdata;
  assign g_wstrb   = gnt_q ? m1_Wstrb   : m0_Wstrb;
  assign g_wvalid  = gnt_q ? m1_Wvalid  : m0_Wvalid;
  assign g_bready  = gnt_q ? m1_Bready  : m0_Bready;
  assign g_ardata  = gnt_q ? m1_ARdata  : m0_ARdata;
  assign g_arprot  = gnt_q ? m1_ARprot  : m0_ARprot;
  assign g_arvalid = gnt_q ? m1_ARvalid : m0_ARvalid;
  assign g_rready  = gnt_q ? m1_Rready  : m0_Rready;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    ar_done_d = ar_done_q;
    win       = 1'b0;
    win_wr    = 1'b0;
    win_rd    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          // Round-robin favours the master not served last; reset value of last gives m0 first turn
          if (req0 & req1) win = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
          else             win = req1;
          win_wr    = win ? req1_wr : req0_wr;
          win_rd    = win ? req1_rd : req0_rd;
          gnt_d     = win;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          ar_done_d = 1'b0;
          state_d   = (win_wr && (!win_rd || WRITE_FIRST != 0)) ? WRITE : READ;
        end
      end
      WRITE: begin
        if (s_AWvalid & s_AWready) aw_done_d = 1'b1;
        if (s_Wvalid & s_Wready)   w_done_d  = 1'b1;
        if (s_Bvalid & s_Bready) begin
          state_d = IDLE;
          last_d  = gnt_q;
        end
      end
      READ: begin
        if (s_ARvalid & s_ARready) ar_done_d = 1'b1;
        if (s_Rvalid & s_Rready) begin
          state_d = IDLE;
          last_d  = gnt_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_AWdata   = '0;
    s_AWprot   = '0;
    s_AWvalid  = 1'b0;
    s_Wdata    = '0;
    s_Wstrb    = '0;
    s_Wvalid   = 1'b0;
    s_Bready   = 1'b0;
    s_ARdata   = '0;
    s_ARprot   = '0;
    s_ARvalid  = 1'b0;
    s_Rready   = 1'b0;
    m0_AWready = 1'b0;
    m0_Wready  = 1'b0;
    m0_Bvalid  = 1'b0;
    m0_ARready = 1'b0;
    m0_Rvalid  = 1'b0;
    m0_Rdata   = '0;
    m1_AWready = 1'b0;
    m1_Wready  = 1'b0;
    m1_Bvalid  = 1'b0;
    m1_ARready = 1'b0;
    m1_Rvalid  = 1'b0;
    m1_Rdata   = '0;
    owner      = 2'b00;
    case (state_q)
      WRITE: begin
        owner      = gnt_q ? 2'b10 : 2'b01;
        s_AWdata   = g_awdata;
        s_AWprot   = g_awprot;
        s_AWvalid  = g_awvalid & ~aw_done_q;
        s_Wdata    = g_wdata;
        s_Wstrb    = g_wstrb;
        s_Wvalid   = g_wvalid & ~w_done_q;
        // Response is only accepted once both address and data have been handed over
        s_Bready   = g_bready & aw_done_q & w_done_q;
        m0_AWready = ~gnt_q & s_AWready & ~aw_done_q;
        m0_Wready  = ~gnt_q & s_Wready & ~w_done_q;
        m0_Bvalid  = ~gnt_q & s_Bvalid;
        m1_AWready = gnt_q & s_AWready & ~aw_done_q;
        m1_Wready  = gnt_q & s_Wready & ~w_done_q;
        m1_Bvalid  = gnt_q & s_Bvalid;
      end
      READ: begin
        owner      = gnt_q ? 2'b10 : 2'b01;
        s_ARdata   = g_ardata;
        s_ARprot   = g_arprot;
        s_ARvalid  = g_arvalid & ~ar_done_q;
        s_Rready   = g_rready;
        m0_ARready = ~gnt_q & s_ARready & ~ar_done_q;
        m0_Rvalid  = ~gnt_q & s_Rvalid;
        m0_Rdata   = gnt_q ? 32'h0 : s_Rdata;
        m1_ARready = gnt_q & s_ARready & ~ar_done_q;
        m1_Rvalid  = gnt_q & s_Rvalid;
        m1_Rdata   = gnt_q ? s_Rdata : 32'h0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      ar_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      ar_done_q <= ar_done_d;
    end
  end

endmodule

// File: tb/tb_axil_arbiter_2m.sv
// Bench for axil_arbiter_2m: two instances (round-robin/write-first and fixed-priority/read-first)
// share directed stimulus; a transaction-level model predicts every output each cycle.
module tb_axil_arbiter_2m;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;

  logic [31:0] m_awdata[2], m_ardata[2], m_wdata[2];
  logic [2:0]  m_awprot[2], m_arprot[2];
  logic [3:0]  m_wstrb[2];
  logic        m_awvalid[2], m_wvalid[2], m_arvalid[2], m_bready[2], m_rready[2];
  logic        s_awready, s_wready, s_arready, s_bvalid, s_rvalid;
  logic [31:0] s_rdata;

  logic        o_awready[2][2], o_wready[2][2], o_arready[2][2], o_bvalid[2][2], o_rvalid[2][2];
  logic [31:0] o_rdata[2][2];
  logic [31:0] o_s_awdata[2], o_s_ardata[2], o_s_wdata[2];
  logic [2:0]  o_s_awprot[2], o_s_arprot[2];
  logic [3:0]  o_s_wstrb[2];
  logic        o_s_awvalid[2], o_s_wvalid[2], o_s_arvalid[2], o_s_bready[2], o_s_rready[2];
  logic [1:0]  o_owner[2];

  for (genvar d = 0; d < 2; d++) begin : g_dut
    axil_arbiter_2m #(.FIXED_PRIO(d), .WRITE_FIRST(1 - d)) u_dut (
      .clk(clk), .rstn(rstn),
      .m0_AWdata(m_awdata[0]), .m0_AWprot(m_awprot[0]), .m0_AWvalid(m_awvalid[0]), .m0_AWready(o_awready[d][0]),
      .m0_Wdata(m_wdata[0]), .m0_Wstrb(m_wstrb[0]), .m0_Wvalid(m_wvalid[0]), .m0_Wready(o_wready[d][0]),
      .m0_Bvalid(o_bvalid[d][0]), .m0_Bready(m_bready[0]),
      .m0_ARdata(m_ardata[0]), .m0_ARprot(m_arprot[0]), .m0_ARvalid(m_arvalid[0]), .m0_ARready(o_arready[d][0]),
      .m0_Rdata(o_rdata[d][0]), .m0_Rvalid(o_rvalid[d][0]), .m0_Rready(m_rready[0]),
      .m1_AWdata(m_awdata[1]), .m1_AWprot(m_awprot[1]), .m1_AWvalid(m_awvalid[1]), .m1_AWready(o_awready[d][1]),
      .m1_Wdata(m_wdata[1]), .m1_Wstrb(m_wstrb[1]), .m1_Wvalid(m_wvalid[1]), .m1_Wready(o_wready[d][1]),
      .m1_Bvalid(o_bvalid[d][1]), .m1_Bready(m_bready[1]),
      .m1_ARdata(m_ardata[1]), .m1_ARprot(m_arprot[1]), .m1_ARvalid(m_arvalid[1]), .m1_ARready(o_arready[d][1]),
      .m1_Rdata(o_rdata[d][1]), .m1_Rvalid(o_rvalid[d][1]), .m1_Rready(m_rready[1]),
      .s_AWdata(o_s_awdata[d]), .s_AWprot(o_s_awprot[d]), .s_AWvalid(o_s_awvalid[d]), .s_AWready(s_awready),
      .s_Wdata(o_s_wdata[d]), .s_Wstrb(o_s_wstrb[d]), .s_Wvalid(o_s_wvalid[d]), .s_Wready(s_wready),
      .s_Bvalid(s_bvalid), .s_Bready(o_s_bready[d]),
      .s_ARdata(o_s_ardata[d]), .s_ARprot(o_s_arprot[d]), .s_ARvalid(o_s_arvalid[d]), .s_ARready(s_arready),
      .s_Rdata(s_rdata), .s_Rvalid(s_rvalid), .s_Rready(o_s_rready[d]),
      .owner(o_owner[d])
    );
  end

  int checks, failures, aw_cnt, w_cnt;

  task automatic chk(input string nm, input logic [186:0] act, input logic [186:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Model: which master owns the bus (-1 = none), the kind of transfer, which phases are done
  typedef struct packed {
    logic signed [31:0] cur;
    logic iswr, awd, wd, ard, lst;
  } mst_t;
  mst_t ms[2];

  function automatic mst_t model_next(input int d);
    mst_t n = ms[d];
    int   g = ms[d].cur;
    logic r0, r1, rw, rr;
    int   w;
    if (g < 0) begin
      r0 = m_awvalid[0] | m_wvalid[0] | m_arvalid[0];
      r1 = m_awvalid[1] | m_wvalid[1] | m_arvalid[1];
      if (r0 || r1) begin
        if (r0 && r1) w = (d == 1) ? 0 : (ms[d].lst ? 0 : 1);
        else          w = r1 ? 1 : 0;
        rw = m_awvalid[w] | m_wvalid[w];
        rr = m_arvalid[w];
        n.cur  = w;
        n.iswr = rw && (!rr || d == 0);
        n.awd  = 1'b0;
        n.wd   = 1'b0;
        n.ard  = 1'b0;
      end
    end else if (ms[d].iswr) begin
      if (m_awvalid[g] && s_awready) n.awd = 1'b1;
      if (m_wvalid[g] && s_wready)   n.wd  = 1'b1;
      if (s_bvalid && m_bready[g] && ms[d].awd && ms[d].wd) begin
        n.cur = -1;
        n.lst = (g == 1);
      end
    end else begin
      if (m_arvalid[g] && s_arready) n.ard = 1'b1;
      if (s_rvalid && m_rready[g]) begin
        n.cur = -1;
        n.lst = (g == 1);
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rstn) begin
    for (int d = 0; d < 2; d++) begin
      if (!rstn) ms[d] <= '{cur: -1, iswr: 1'b0, awd: 1'b0, wd: 1'b0, ard: 1'b0, lst: 1'b1};
      else       ms[d] <= model_next(d);
    end
  end

  function automatic logic [186:0] exp_vec(input int d);
    logic [1:0]  own = 2'b00;
    logic        sav = 0, swv = 0, sarv = 0, sbr = 0, srr = 0;
    logic [31:0] saw = '0, sar = '0, sw = '0;
    logic [2:0]  sawp = '0, sarp = '0;
    logic [3:0]  sws = '0;
    logic        mawr[2], mwr[2], marr[2], mbv[2], mrv[2];
    logic [31:0] mrd[2];
    int          g = ms[d].cur;
    for (int m = 0; m < 2; m++) begin
      mawr[m] = 0; mwr[m] = 0; marr[m] = 0; mbv[m] = 0; mrv[m] = 0; mrd[m] = '0;
    end
    if (g >= 0) begin
      own = (g == 1) ? 2'b10 : 2'b01;
      if (ms[d].iswr) begin
        saw  = m_awdata[g];
        sawp = m_awprot[g];
        sav  = m_awvalid[g] && !ms[d].awd;
        sw   = m_wdata[g];
        sws  = m_wstrb[g];
        swv  = m_wvalid[g] && !ms[d].wd;
        sbr  = m_bready[g] && ms[d].awd && ms[d].wd;
        mawr[g] = s_awready && !ms[d].awd;
        mwr[g]  = s_wready && !ms[d].wd;
        mbv[g]  = s_bvalid;
      end else begin
        sar  = m_ardata[g];
        sarp = m_arprot[g];
        sarv = m_arvalid[g] && !ms[d].ard;
        srr  = m_rready[g];
        marr[g] = s_arready && !ms[d].ard;
        mrv[g]  = s_rvalid;
        mrd[g]  = s_rdata;
      end
    end
    return {own, sav, swv, sarv, sbr, srr, saw, sar, sw, sawp, sarp, sws,
            mawr[1], mwr[1], marr[1], mbv[1], mrv[1], mrd[1],
            mawr[0], mwr[0], marr[0], mbv[0], mrv[0], mrd[0]};
  endfunction

  function automatic logic [186:0] act_vec(input int d);
    return {o_owner[d], o_s_awvalid[d], o_s_wvalid[d], o_s_arvalid[d], o_s_bready[d], o_s_rready[d],
            o_s_awdata[d], o_s_ardata[d], o_s_wdata[d], o_s_awprot[d], o_s_arprot[d], o_s_wstrb[d],
            o_awready[d][1], o_wready[d][1], o_arready[d][1], o_bvalid[d][1], o_rvalid[d][1], o_rdata[d][1],
            o_awready[d][0], o_wready[d][0], o_arready[d][0], o_bvalid[d][0], o_rvalid[d][0], o_rdata[d][0]};
  endfunction

  initial begin
    aw_cnt = 0;
    w_cnt  = 0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) chk($sformatf("cycle_dut%0d", d), act_vec(d), exp_vec(d));
      if (rstn && o_s_awvalid[0] && s_awready) aw_cnt++;
      if (rstn && o_s_wvalid[0] && s_wready)   w_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int m = 0; m < 2; m++) begin
      m_awdata[m] = '0; m_ardata[m] = '0; m_wdata[m] = '0;
      m_awprot[m] = '0; m_arprot[m] = '0; m_wstrb[m] = '0;
      m_awvalid[m] = 0; m_wvalid[m] = 0; m_arvalid[m] = 0; m_bready[m] = 0; m_rready[m] = 0;
    end
    s_awready = 0; s_wready = 0; s_arready = 0; s_bvalid = 0; s_rvalid = 0; s_rdata = '0;
  endtask

  int c0_m1, c1_m1, c1_m0, aw0, w0;

  initial begin
    checks = 0;
    failures = 0;
    clear_inputs();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_owner", o_owner[0], 2'b00);
    chk("reset_outputs_dut1", act_vec(1), '0);
    rstn = 1'b1;

    // Single read by m0
    tick();
    m_ardata[0] = 32'h100; m_arvalid[0] = 1; m_rready[0] = 1; s_arready = 1;
    tick();
    #1;
    chk("rd_owner", o_owner[0], 2'b01);
    chk("rd_s_ardata", o_s_ardata[0], 32'h100);
    chk("rd_m1_arready", o_arready[0][1], 0);
    tick();
    m_arvalid[0] = 0;
    tick();
    s_rvalid = 1; s_rdata = 32'hDEADBEEF;
    #1;
    chk("rd_m0_rdata", o_rdata[0][0], 32'hDEADBEEF);
    chk("rd_m1_rvalid", o_rvalid[0][1], 0);
    chk("rd_owner_xfer", o_owner[0], 2'b01);
    tick();
    s_rvalid = 0;
    #1;
    chk("rd_owner_after", o_owner[0], 2'b00);

    // Contention after m0 was served: round-robin picks m1, fixed priority picks m0
    m_ardata[0] = 32'h110; m_ardata[1] = 32'h210; m_arvalid[0] = 1; m_arvalid[1] = 1; m_rready[1] = 1;
    tick();
    #1;
    chk("rr_first_m1", o_owner[0], 2'b10);
    chk("fp_first_m0", o_owner[1], 2'b01);
    tick();
    m_arvalid[1] = 0;
    s_rvalid = 1; s_rdata = 32'h11111111;
    #1;
    chk("rr_m1_rdata", o_rdata[0][1], 32'h11111111);
    chk("rr_m0_rdata_zero", o_rdata[0][0], 32'h0);
    tick();
    s_rvalid = 0;
    tick();
    #1;
    chk("rr_second_m0", o_owner[0], 2'b01);
    tick();
    m_arvalid[0] = 0;
    s_rvalid = 1; s_rdata = 32'h22222222;
    tick();
    s_rvalid = 0;

    // Continuous requests from both masters with an always-ready slave
    m_arvalid[0] = 1; m_arvalid[1] = 1; s_rvalid = 1; s_rdata = 32'h33333333;
    c0_m1 = 0; c1_m1 = 0; c1_m0 = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      #1;
      if (o_owner[0] == 2'b10) c0_m1++;
      if (o_owner[1] == 2'b10) c1_m1++;
      if (o_owner[1] == 2'b01) c1_m0++;
    end
    m_arvalid[0] = 0; m_arvalid[1] = 0; s_rvalid = 0;
    chk("rr_m1_grants", c0_m1, 4);
    chk("fp_m1_grants", c1_m1, 0);
    chk("fp_m0_grants", c1_m0, 8);

    // m1 write with W accepted well before AW
    aw0 = aw_cnt; w0 = w_cnt;
    m_awdata[1] = 32'h200; m_awprot[1] = 3'b010; m_wdata[1] = 32'hCAFEF00D; m_wstrb[1] = 4'hF;
    m_awvalid[1] = 1; m_wvalid[1] = 1; m_bready[1] = 1; s_wready = 1; s_awready = 0;
    tick();
    #1;
    chk("wr_owner", o_owner[0], 2'b10);
    chk("wr_s_wdata", o_s_wdata[0], 32'hCAFEF00D);
    chk("wr_s_awprot", o_s_awprot[0], 3'b010);
    tick();
    tick();
    tick();
    s_awready = 1;
    #1;
    chk("wr_w_masked", o_s_wvalid[0], 0);
    chk("wr_m1_awready", o_awready[0][1], 1);
    tick();
    m_awvalid[1] = 0; m_wvalid[1] = 0; s_awready = 0; s_bvalid = 1;
    #1;
    chk("wr_m1_bvalid", o_bvalid[0][1], 1);
    chk("wr_m0_bvalid", o_bvalid[0][0], 0);
    chk("wr_s_bready", o_s_bready[0], 1);
    tick();
    s_bvalid = 0;
    #1;
    chk("wr_owner_after", o_owner[0], 2'b00);
    chk("wr_aw_hs", aw_cnt - aw0, 1);
    chk("wr_w_hs", w_cnt - w0, 1);

    // m1 presents write and read together
    m_awdata[1] = 32'h204; m_wdata[1] = 32'h12345678; m_ardata[1] = 32'h300;
    m_awvalid[1] = 1; m_wvalid[1] = 1; m_arvalid[1] = 1; m_rready[1] = 1;
    s_awready = 1; s_wready = 1; s_arready = 1;
    tick();
    #1;
    chk("wf_dut0_aw", o_s_awvalid[0], 1);
    chk("wf_dut0_ar", o_s_arvalid[0], 0);
    chk("rf_dut1_ar", o_s_arvalid[1], 1);
    chk("rf_dut1_aw", o_s_awvalid[1], 0);
    tick();
    m_awvalid[1] = 0; m_wvalid[1] = 0; s_bvalid = 1;
    tick();
    s_bvalid = 0;
    #1;
    chk("wf_gap_ar", o_s_arvalid[0], 0);
    chk("wf_gap_owner", o_owner[0], 2'b00);
    tick();
    #1;
    chk("wf_then_ar", o_s_arvalid[0], 1);
    chk("wf_then_owner", o_owner[0], 2'b10);
    tick();
    #1;
    chk("rd_ar_masked", o_s_arvalid[0], 0);
    chk("rd_s_rready", o_s_rready[0], 1);

    // Asynchronous reset in READ after the AR handshake
    #1;
    rstn = 1'b0;
    #1;
    chk("rst_s_rready", o_s_rready[0], 0);
    chk("rst_owner", o_owner[0], 2'b00);
    chk("rst_all_dut0", act_vec(0), '0);
    chk("rst_all_dut1", act_vec(1), '0);
    clear_inputs();
    tick();
    rstn = 1'b1;
    m_ardata[1] = 32'h400; m_arvalid[1] = 1; m_rready[1] = 1; s_arready = 1;
    tick();
    #1;
    chk("post_rst_dut0", o_owner[0], 2'b10);
    chk("post_rst_dut1", o_owner[1], 2'b10);
    tick();
    m_arvalid[1] = 0; s_rvalid = 1; s_rdata = 32'h44444444;
    tick();
    s_rvalid = 0;

    // m0 write whose response is held off by Bready
    m_awdata[0] = 32'h500; m_wdata[0] = 32'hA5A5A5A5; m_wstrb[0] = 4'h3;
    m_awvalid[0] = 1; m_wvalid[0] = 1; m_bready[0] = 0; s_awready = 1; s_wready = 1;
    tick();
    tick();
    m_awvalid[0] = 0; m_wvalid[0] = 0; s_bvalid = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("bp_m0_bvalid_%0d", i), o_bvalid[0][0], 1);
      chk($sformatf("bp_s_bready_%0d", i), o_s_bready[0], 0);
      chk($sformatf("bp_owner_%0d", i), o_owner[0], 2'b01);
      tick();
    end
    m_bready[0] = 1;
    #1;
    chk("bp_release", o_s_bready[0], 1);
    tick();
    s_bvalid = 0;
    #1;
    chk("bp_owner_after", o_owner[0], 2'b00);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
